mem_arbiter: RTL

//  Shares the single RAM port between the icache (read-only) and dcache (read/write) requesters.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache (read-only) and dcache (read/write); D wins unless I has starved MAX_STREAK grants.
// Grant 1 cycle after request, wait released in the ACCESS cycle, one IDLE cycle between transactions; watchdog aborts silent RAM.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] iload,
  output logic          iwait,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic [DW-1:0] dload,
  output logic          dwait,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic [1:0]    ramstate,
  output logic          err
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          d_pend;
  logic          access;
  logic          owner_req;

  assign d_pend = dREN | dWEN;
  assign access = (ramstate == RS_ACCESS);
  assign iload  = ramload;
  assign dload  = ramload;
  assign err    = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    owner_req = 1'b0;

    case (state_q)
      IDLE: begin
        // I is forced in only once D has taken MAX_STREAK grants while I waited
        if (d_pend && !(iREN && streak_q == SW'(MAX_STREAK))) begin
          state_d = DGNT;
          wdog_d  = '0;
          if (!iREN)
            streak_d = '0;
          else if (streak_q != SW'(MAX_STREAK))
            streak_d = streak_q + 1'b1;
        end else if (iREN) begin
          state_d  = IGNT;
          streak_d = '0;
          wdog_d   = '0;
        end
      end
      IGNT: begin
        ramREN    = iREN;
        ramaddr   = iaddr;
        iwait     = ~access;
        owner_req = iREN;
      end
      DGNT: begin
        ramWEN    = dWEN;
        ramREN    = dREN & ~dWEN;
        ramaddr   = daddr;
        ramstore  = dstore;
        dwait     = ~access;
        owner_req = d_pend;
      end
      default: state_d = IDLE;
    endcase

    // ACCESS beats withdrawal; withdrawal ends the grant quietly without flagging err
    if (state_q != IDLE) begin
      if (access || !owner_req) begin
        state_d = IDLE;
      end else if (ramstate == RS_ERROR || wdog_q == WW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

endmodule
